lsu_mem_port: RTL
=================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter ADDR_W, default 8, memory byte-address width.
REQ-002 Parameter WAIT_CYCLES, default 1, cycles from driving a read address to sampling mem_rdata (legal range 1..15).
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1, core presents a load/store request.
REQ-006 Port req_ready, output, 1, block accepts a request this cycle.
REQ-007 Port req_write, input, 1, 1 = store, 0 = load.
REQ-008 Port req_size, input, 3, access size: 3'b001 byte, 3'b010 half, 3'b100 word.
REQ-009 Port req_signed, input, 1, load result sign-extended when 1, zero-extended when 0.
REQ-010 Port req_addr, input, 32, byte address.
REQ-011 Port req_wdata, input, 32, store data, least-significant byte first in memory.
REQ-012 Port resp_valid, output, 1, response available.
REQ-013 Port resp_ready, input, 1, core consumes the response.
REQ-014 Port resp_rdata, output, 32, extended load data; 0 for stores and errors.
REQ-015 Port resp_err, output, 1, request rejected (misaligned, illegal size or out of range).
REQ-016 Port mem_address, output, ADDR_W, byte address to memory.
REQ-017 Port mem_bytes, output, 3, read size to memory, same encoding as req_size.
REQ-018 Port mem_wdata, output, 32, write bus; only bits [7:0] are stored per write.
REQ-019 Port mem_write, output, 1, byte write strobe.
REQ-020 Port mem_signed, output, 1, forwarded req_signed.
REQ-021 Port mem_rdata, input, 32, memory read data.

Function
REQ-022 The block SHALL be an FSM with states IDLE, STORE, LOAD, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready, and all request fields are registered then.
REQ-024 On accept, an error SHALL be flagged for: size not in {001,010,100}, half with addr[0]=1, word with addr[1:0]!=0, or addr+size-1 >= 2^ADDR_W; an error goes directly to RESP with resp_err=1, resp_rdata=0, and no memory activity.
REQ-025 A legal store SHALL go to STORE and issue N=size byte writes on N consecutive cycles: mem_write=1, mem_address=addr+k, mem_wdata={24'h0, wdata byte k}, k=0..N-1, then go to RESP.
REQ-026 A legal load SHALL go to LOAD with mem_bytes=size, mem_signed=req_signed, mem_address=addr, mem_write=0, held for WAIT_CYCLES cycles; mem_rdata is sampled on the final LOAD cycle, then go to RESP.
REQ-027 The block SHALL itself extend the sampled load data to 32 bits per size/req_signed (byte: bit 7, half: bit 15) and ignore mem_rdata bits above the access size.
REQ-028 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err stable until resp_valid && resp_ready, after which the FSM returns to IDLE (next accept no earlier than the following cycle).
REQ-029 mem_write SHALL be 0 in every state other than STORE; mem_address, mem_bytes, mem_wdata and mem_signed SHALL be 0 in IDLE and RESP.
REQ-030 Latency: store resp_valid asserts N+1 cycles after accept; load resp_valid asserts WAIT_CYCLES+1 cycles after accept; error resp_valid asserts 1 cycle after accept.

Reset
REQ-031 reset asserted at any time, including mid-store, SHALL immediately force IDLE, all outputs 0 except req_ready=1, and clear the byte and wait counters; a partially written store is not completed or retried.

Structure
REQ-032 The size encodings (BYTE/HALF/WORD) and FSM state encodings SHALL live in a shared package also used by the memory and decode logic.
REQ-033 The load extension SHALL be a separate combinational sub-module named load_extend (inputs data, size, signed; output 32-bit result).

Verification
REQ-034 Store word 0xDEADBEEF at 0x10 -> 4 write cycles to 0x10..0x13 with bytes EF,BE,AD,DE; resp_valid on cycle 5, resp_err=0.
REQ-035 Load byte signed at 0x10 with mem_rdata=0x000000EF -> resp_rdata=0xFFFFFFEF; unsigned -> 0x000000EF.
REQ-036 Load half at 0x11 -> resp_err=1 one cycle after accept, no mem_write, mem_address=0.
REQ-037 Store word at 0xFE (ADDR_W=8) and req_size=3'b011 -> both resp_err=1, no memory writes.
REQ-038 reset asserted after 2nd byte of a word store -> outputs cleared immediately, req_ready=1, only 0x10,0x11 written.
REQ-039 resp_ready held 0 for 3 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0 throughout.

Source files
------------

// File: rtl/lsu_mem_port_pkg.sv
// Shared encodings for the load/store memory port: access sizes, FSM states
// and small decode helpers used by the control FSM and the load extender.
package lsu_mem_port_pkg;

  // Size encodings are one-hot and double as the byte count of the access.
  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b010;
  localparam logic [2:0] SZ_WORD = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    return size_legal(size) ? size : 3'd0;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// Extends raw memory read data to 32 bits according to access size and
// signedness; bits above the access size are ignored.
module load_extend
  import lsu_mem_port_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: result_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: accepts one core request at a time, serialises
// stores into byte writes, waits out memory latency for loads, then responds.
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [2:0]        mem_bytes,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_signed,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        wait_q, wait_d;
  logic              err_q, err_d;

  logic [2:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              capture_req;
  logic              capture_load;
  logic              req_err;
  logic [32:0]       last_addr;
  logic [31:0]       ext_data;
  logic [7:0]        wbyte;

  // Range check on the full request address: the last byte touched must fit in ADDR_W.
  assign last_addr = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
  assign req_err   = !size_legal(req_size) || misaligned(req_size, req_addr[1:0]) ||
                     ((last_addr >> ADDR_W) != 33'd0);

  assign wbyte = wdata_q[{cnt_q, 3'b000} +: 8];

  load_extend u_load_extend (
    .data_i   (mem_rdata),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      wait_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Request fields and load result are only observed once the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (capture_req) begin
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr[ADDR_W-1:0];
      wdata_q  <= req_wdata;
      rdata_q  <= 32'd0;
    end else if (capture_load) begin
      rdata_q  <= ext_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    err_d        = err_q;
    capture_req  = 1'b0;
    capture_load = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = 32'd0;
    resp_err     = 1'b0;
    mem_address  = '0;
    mem_bytes    = 3'd0;
    mem_wdata    = 32'd0;
    mem_write    = 1'b0;
    mem_signed   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture_req = 1'b1;
          cnt_d       = 2'd0;
          wait_d      = 4'd0;
          err_d       = req_err;
          if (req_err)        state_d = ST_RESP;
          else if (req_write) state_d = ST_STORE;
          else                state_d = ST_LOAD;
        end
      end
      ST_STORE: begin
        mem_write   = 1'b1;
        mem_address = addr_q + ADDR_W'(cnt_q);
        mem_wdata   = {24'h0, wbyte};
        if ({1'b0, cnt_q} == size_bytes(size_q) - 3'd1) state_d = ST_RESP;
        else                                           cnt_d   = cnt_q + 2'd1;
      end
      ST_LOAD: begin
        mem_address = addr_q;
        mem_bytes   = size_q;
        mem_signed  = signed_q;
        if (wait_q == WAIT_LAST) begin
          capture_load = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
